// File: rtl/mod13_count_checker.sv
// rtl/mod13_count_checker.sv - lock-step reference checker for the mod-13 up/down counter
//
// Runs a reference model of the counter in parallel with it and flags any
// cycle where the observed count disagrees with the model. It also keeps
// saturating mismatch and compare statistics.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset, both shared with the counter
//   clr           synchronous clear of statistics and sticky flags
//   mode          counter direction as driven to the counter (1 = up, 0 = down)
//   load, data_in counter load strobe and load value as driven to the counter
//   count         observed counter output
//   exp_count     model value the checker expects on count this cycle
//   in_sync       1 while the checker is comparing (CHECK state)
//   mismatch      one-cycle pulse per detected mismatch
//   illegal_load  one-cycle pulse when a load with data_in >= MOD is seen
//   sticky_err    set on the first mismatch, held until clr or rst
//   first_exp     expected value at the first mismatch since clr
//   first_act     observed value at the first mismatch since clr
//   err_cnt       saturating mismatch count
//   chk_cnt       saturating compare count

module mod13_count_checker #(
    parameter int MOD = 13,
    parameter int CW  = 4,
    parameter int SW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          mode,
    input  logic          load,
    input  logic [CW-1:0] data_in,
    input  logic [CW-1:0] count,
    output logic [CW-1:0] exp_count,
    output logic          in_sync,
    output logic          mismatch,
    output logic          illegal_load,
    output logic          sticky_err,
    output logic [CW-1:0] first_exp,
    output logic [CW-1:0] first_act,
    output logic [SW-1:0] err_cnt,
    output logic [SW-1:0] chk_cnt
);

    typedef enum logic {
        ST_CHECK  = 1'b0,
        ST_RESYNC = 1'b1
    } state_t;

    // One extra bit so that the legality compare also works when MOD == 2**CW.
    localparam logic [CW:0]   MOD_X = (CW+1)'(MOD);
    localparam logic [CW-1:0] MAX_V = CW'(MOD - 1);

    state_t        state_q,        state_d;
    logic [CW-1:0] model_q,        model_d;
    logic          mismatch_q,     mismatch_d;
    logic          illegal_load_q, illegal_load_d;
    logic          sticky_err_q,   sticky_err_d;
    logic [CW-1:0] first_exp_q,    first_exp_d;
    logic [CW-1:0] first_act_q,    first_act_d;
    logic [SW-1:0] err_cnt_q,      err_cnt_d;
    logic [SW-1:0] chk_cnt_q,      chk_cnt_d;

    logic          data_ok;
    logic          count_ok;
    logic          bad;
    logic          ill_ld;
    logic [CW-1:0] seed;

    // Counter next-state function; load has priority over direction.
    function automatic logic [CW-1:0] nxt_val(
        input logic [CW-1:0] v,
        input logic          m,
        input logic          ld,
        input logic [CW-1:0] d
    );
        if (ld) begin
            return d;
        end else if (m) begin
            return (v == MAX_V) ? '0 : v + CW'(1);
        end else begin
            return (v == '0) ? MAX_V : v - CW'(1);
        end
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == '1) ? v : v + SW'(1);
    endfunction

    always_comb begin
        data_ok  = ({1'b0, data_in} < MOD_X);
        count_ok = ({1'b0, count} < MOD_X);
        ill_ld   = load && !data_ok;
        bad      = (count != model_q) || !count_ok;
        // An out-of-range observation cannot seed the model; restart from 0.
        seed     = count_ok ? count : '0;

        state_d        = state_q;
        model_d        = model_q;
        mismatch_d     = 1'b0;
        illegal_load_d = 1'b0;
        sticky_err_d   = sticky_err_q;
        first_exp_d    = first_exp_q;
        first_act_d    = first_act_q;
        err_cnt_d      = err_cnt_q;
        chk_cnt_d      = chk_cnt_q;

        case (state_q)
            ST_CHECK: begin
                chk_cnt_d = sat_inc(chk_cnt_q);
                if (bad) begin
                    mismatch_d   = 1'b1;
                    err_cnt_d    = sat_inc(err_cnt_q);
                    sticky_err_d = 1'b1;
                    if (!sticky_err_q) begin
                        first_exp_d = model_q;
                        first_act_d = count;
                    end
                end
                if (ill_ld) begin
                    // The counter's value after an illegal load is unknown;
                    // keep the model legal and wait for a good load.
                    illegal_load_d = 1'b1;
                    state_d        = ST_RESYNC;
                end else begin
                    // Re-seeding from the observed value reports a single
                    // fault once instead of on every following cycle.
                    model_d = nxt_val(bad ? seed : model_q, mode, load, data_in);
                end
            end
            ST_RESYNC: begin
                if (load && data_ok) begin
                    model_d = data_in;
                    state_d = ST_CHECK;
                end else if (ill_ld) begin
                    illegal_load_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CHECK;
            end
        endcase

        // Clear wins over the statistics but never suppresses the pulse.
        if (clr) begin
            err_cnt_d    = '0;
            chk_cnt_d    = '0;
            sticky_err_d = 1'b0;
            first_exp_d  = '0;
            first_act_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_CHECK;
            model_q        <= '0;
            mismatch_q     <= 1'b0;
            illegal_load_q <= 1'b0;
            sticky_err_q   <= 1'b0;
            first_exp_q    <= '0;
            first_act_q    <= '0;
            err_cnt_q      <= '0;
            chk_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            model_q        <= model_d;
            mismatch_q     <= mismatch_d;
            illegal_load_q <= illegal_load_d;
            sticky_err_q   <= sticky_err_d;
            first_exp_q    <= first_exp_d;
            first_act_q    <= first_act_d;
            err_cnt_q      <= err_cnt_d;
            chk_cnt_q      <= chk_cnt_d;
        end
    end

    assign exp_count    = model_q;
    assign in_sync      = (state_q == ST_CHECK);
    assign mismatch     = mismatch_q;
    assign illegal_load = illegal_load_q;
    assign sticky_err   = sticky_err_q;
    assign first_exp    = first_exp_q;
    assign first_act    = first_act_q;
    assign err_cnt      = err_cnt_q;
    assign chk_cnt      = chk_cnt_q;

endmodule

// File: tb/tb_mod13_count_checker.sv
// tb/tb_mod13_count_checker.sv - directed scoreboard bench for mod13_count_checker

module tb_mod13_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       mode = 1'b1;
    logic       load = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] count = 4'd0;

    logic [3:0]  exp_count, first_exp, first_act;
    logic        in_sync, mismatch, illegal_load, sticky_err;
    logic [15:0] err_cnt, chk_cnt;

    logic [3:0]  exp_count_s, first_exp_s, first_act_s;
    logic        in_sync_s, mismatch_s, illegal_load_s, sticky_err_s;
    logic [3:0]  err_cnt_s, chk_cnt_s;

    mod13_count_checker #(.MOD(13), .CW(4), .SW(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .load(load),
        .data_in(data_in), .count(count), .exp_count(exp_count),
        .in_sync(in_sync), .mismatch(mismatch), .illegal_load(illegal_load),
        .sticky_err(sticky_err), .first_exp(first_exp), .first_act(first_act),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt)
    );

    mod13_count_checker #(.MOD(13), .CW(4), .SW(4)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .load(load),
        .data_in(data_in), .count(count), .exp_count(exp_count_s),
        .in_sync(in_sync_s), .mismatch(mismatch_s), .illegal_load(illegal_load_s),
        .sticky_err(sticky_err_s), .first_exp(first_exp_s), .first_act(first_act_s),
        .err_cnt(err_cnt_s), .chk_cnt(chk_cnt_s)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    bit         exp_q[$];
    bit         in_check = 1'b1;
    int         exp_chk = 0;
    logic [3:0] ref_v;
    logic [3:0] bad;
    logic [3:0] save_exp;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] v, input logic m,
                                       input logic ld, input logic [3:0] d);
        if (ld) return d;
        if (m) return (v == 4'd12) ? 4'd0 : v + 4'd1;
        return (v == 4'd0) ? 4'd12 : v - 4'd1;
    endfunction

    // Drive one cycle of counter activity; the expected mismatch for this
    // cycle's compare is queued and checked one cycle later.
    task automatic drive(input logic m, input logic ld, input logic [3:0] d,
                         input logic [3:0] c, input bit exp_mis);
        bit e;
        mode = m; load = ld; data_in = d; count = c;
        exp_q.push_back(exp_mis);
        if (in_check) exp_chk++;
        if (clr) exp_chk = 0;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("mismatch", {15'd0, mismatch}, {15'd0, e});
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exp_count", exp_count, 0);
        chk("rst_in_sync", in_sync, 1);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_chk_cnt", chk_cnt, 0);
        chk("rst_sticky", sticky_err, 0);
        rst = 1'b0;

        // Up-count wrap, fault-free
        ref_v = 4'd0;
        for (int i = 0; i < 15; i++) begin
            chk("up_exp_count", exp_count, ref_v);
            drive(1'b1, 1'b0, 4'd0, ref_v, 1'b0);
            ref_v = nxt(ref_v, 1'b1, 1'b0, 4'd0);
        end
        chk("up_chk_cnt", chk_cnt, 15);
        chk("up_err_cnt", err_cnt, 0);

        // Down wrap after load of 2
        drive(1'b0, 1'b1, 4'd2, ref_v, 1'b0);
        ref_v = 4'd2;
        for (int i = 0; i < 4; i++) begin
            chk("down_exp_count", exp_count, ref_v);
            drive(1'b0, 1'b0, 4'd0, ref_v, 1'b0);
            ref_v = nxt(ref_v, 1'b0, 1'b0, 4'd0);
        end
        chk("down_exp_11", exp_count, 11);

        // Injected fault: model expects 5, counter shows 7
        drive(1'b1, 1'b1, 4'd5, ref_v, 1'b0);
        ref_v = 4'd5;
        chk("fault_pre_exp", exp_count, 5);
        drive(1'b1, 1'b0, 4'd0, 4'd7, 1'b1);
        ref_v = 4'd8;
        chk("fault_err_cnt", err_cnt, 1);
        chk("fault_first_exp", first_exp, 5);
        chk("fault_first_act", first_act, 7);
        chk("fault_sticky", sticky_err, 1);
        chk("fault_reseed", exp_count, 8);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 4'd0, ref_v, 1'b0);
            ref_v = nxt(ref_v, 1'b1, 1'b0, 4'd0);
        end
        chk("fault_err_hold", err_cnt, 1);

        // Illegal load, then recovery
        drive(1'b1, 1'b1, 4'd14, ref_v, 1'b0);
        in_check = 1'b0;
        chk("ill_pulse", illegal_load, 1);
        chk("ill_in_sync", in_sync, 0);
        chk("ill_chk_cnt", chk_cnt, exp_chk);
        drive(1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
        chk("ill_pulse_end", illegal_load, 0);
        chk("ill_chk_frozen", chk_cnt, exp_chk);
        drive(1'b1, 1'b1, 4'd15, 4'd2, 1'b0);
        chk("ill_again", illegal_load, 1);
        chk("ill_again_sync", in_sync, 0);
        drive(1'b1, 1'b1, 4'd3, 4'd11, 1'b0);
        in_check = 1'b1;
        chk("resync_in_sync", in_sync, 1);
        chk("resync_exp", exp_count, 3);
        chk("resync_chk_frozen", chk_cnt, exp_chk);
        drive(1'b1, 1'b0, 4'd0, 4'd3, 1'b0);
        ref_v = 4'd4;
        chk("resync_chk_resume", chk_cnt, exp_chk);

        // Clear, out-of-range count, saturation
        clr = 1'b1;
        drive(1'b1, 1'b0, 4'd0, ref_v, 1'b0);
        clr = 1'b0;
        ref_v = nxt(ref_v, 1'b1, 1'b0, 4'd0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_err_cnt_s", err_cnt_s, 0);
        chk("clr_chk_cnt", chk_cnt, 0);
        save_exp = ref_v;
        drive(1'b1, 1'b0, 4'd0, 4'd14, 1'b1);
        ref_v = 4'd1;
        chk("oor_first_act", first_act, 14);
        chk("oor_first_exp", first_exp, save_exp);
        chk("oor_reseed", exp_count, 1);
        for (int i = 0; i < 19; i++) begin
            bad = nxt(ref_v, 1'b1, 1'b0, 4'd0);
            drive(1'b1, 1'b0, 4'd0, bad, 1'b1);
            ref_v = nxt(bad, 1'b1, 1'b0, 4'd0);
        end
        chk("sat_err_cnt_s", err_cnt_s, 15);
        chk("sat_err_cnt", err_cnt, 20);
        bad = nxt(ref_v, 1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 4'd0, bad, 1'b1);
        ref_v = nxt(bad, 1'b1, 1'b0, 4'd0);
        chk("sat_hold_s", err_cnt_s, 15);
        chk("sat_err_21", err_cnt, 21);
        chk("sat_first_kept", first_act, 14);
        bad = nxt(ref_v, 1'b1, 1'b0, 4'd0);
        clr = 1'b1;
        drive(1'b1, 1'b0, 4'd0, bad, 1'b1);
        clr = 1'b0;
        ref_v = nxt(bad, 1'b1, 1'b0, 4'd0);
        chk("clrmis_err_cnt", err_cnt, 0);
        chk("clrmis_err_cnt_s", err_cnt_s, 0);
        chk("clrmis_sticky", sticky_err, 0);
        chk("clrmis_first_exp", first_exp, 0);
        chk("clrmis_first_act", first_act, 0);
        chk("clrmis_exp_count", exp_count, ref_v);

        // Async reset while in RESYNC with err_cnt = 3
        for (int i = 0; i < 3; i++) begin
            bad = nxt(ref_v, 1'b1, 1'b0, 4'd0);
            drive(1'b1, 1'b0, 4'd0, bad, 1'b1);
            ref_v = nxt(bad, 1'b1, 1'b0, 4'd0);
        end
        drive(1'b1, 1'b1, 4'd13, ref_v, 1'b0);
        in_check = 1'b0;
        chk("pre_rst_err_cnt", err_cnt, 3);
        chk("pre_rst_in_sync", in_sync, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_exp_count", exp_count, 0);
        chk("arst_in_sync", in_sync, 1);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_chk_cnt", chk_cnt, 0);
        chk("arst_sticky", sticky_err, 0);
        chk("arst_illegal", illegal_load, 0);
        chk("arst_first_act", first_act, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_check = 1'b1;
        exp_chk = 0;
        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("post_rst_chk_cnt", chk_cnt, exp_chk);
        chk("post_rst_exp", exp_count, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mod13_count_checker.md
Name: mod13_count_checker

Overview:
- Hardware checker on the output side of the mod-13 up/down counter. Reads the counter's control inputs (mode, load, data_in) and its count output.
- Runs its own reference model of the counter in lock-step and flags every cycle where the observed count differs from the model.
- Keeps saturating error and compare statistics.
- Sits beside the counter in both the bench and the emulation build, so counter faults show up without a software scoreboard.

Parameters:
- MOD, 13, counter modulus; legal count values are 0..MOD-1.
- CW, 4, width of count and data_in.
- SW, 16, width of the error and compare statistic counters.

Ports:
- clk  input  1  clock, shared with the counter.
- rst  input  1  asynchronous, active-high reset, shared with the counter.
- clr  input  1  synchronous clear of statistics and sticky flags.
- mode  input  1  counter direction as driven to the counter: 1 = up, 0 = down.
- load  input  1  counter load strobe as driven to the counter.
- data_in  input  CW  counter load value.
- count  input  CW  observed counter output.
- exp_count  output  CW  model value the checker expects on count this cycle.
- in_sync  output  1  1 when state is CHECK.
- mismatch  output  1  one-cycle pulse per detected mismatch.
- illegal_load  output  1  one-cycle pulse when load is seen with data_in >= MOD.
- sticky_err  output  1  set on the first mismatch; held until clr or rst.
- first_exp  output  CW  expected value at the first mismatch since clr.
- first_act  output  CW  observed value at the first mismatch since clr.
- err_cnt  output  SW  number of mismatches, saturating.
- chk_cnt  output  SW  number of compares performed, saturating.

Behaviour:
- Reset (async, rst=1): state=CHECK, model=0, all outputs 0, in_sync=1. The counter also resets to 0, so checking starts immediately.
- Model next-state function nxt(v):
  - load=1: nxt = data_in.
  - mode=1: nxt = (v==MOD-1) ? 0 : v+1.
  - mode=0: nxt = (v==0) ? MOD-1 : v-1.
  - load has priority over mode.
- exp_count = model (registered).
- All comparisons at a rising edge use pre-edge values of count and model. A bad count visible in cycle k produces mismatch=1 in cycle k+1 (1-cycle latency).
- State CHECK, at each edge:
  - chk_cnt += 1 (saturates at all-ones).
  - If count != model, or count >= MOD: pulse mismatch, err_cnt += 1 (saturating), and set sticky_err.
  - If sticky_err was 0 at that edge, also capture first_exp=model and first_act=count.
  - On mismatch, re-seed: model <= nxt(count) using the observed value, so one fault is reported once, not every cycle after.
  - If count >= MOD on a mismatch, the re-seed value is nxt(0).
  - With no mismatch: model <= nxt(model).
  - load=1 with data_in >= MOD: pulse illegal_load, go to RESYNC. Compare and mismatch at that edge still apply.
- State RESYNC:
  - No compares: chk_cnt, err_cnt and mismatch are unchanged.
  - load=1 with data_in < MOD: model <= data_in, go to CHECK. The first compare happens at the following edge.
  - Another illegal load: pulse illegal_load again, stay in RESYNC.
- clr (synchronous, rst has priority):
  - Zeros err_cnt, chk_cnt, sticky_err, first_exp, first_act.
  - Does not change state or model.
  - If clr coincides with a mismatch, clr wins for the statistics, but the mismatch pulse is still issued.
- Saturation: a counter at all-ones stays at all-ones and never wraps.
- rst asserted mid-run returns everything to reset values on the next evaluation, regardless of state.

Test Plan:
- Up-count wrap: rst, then mode=1 for 15 cycles, fault-free counter -> count 0..12,0,1 matches exp_count; mismatch never 1; chk_cnt=15; err_cnt=0.
- Down wrap with load: load data_in=2, mode=0 for 4 cycles -> exp_count 2,1,0,12,11; no mismatch.
- Injected fault: force count=7 when the model expects 5 -> mismatch pulses exactly one cycle later; err_cnt=1; first_exp=5, first_act=7; exp_count next = 8 (mode=1); subsequent correct counting gives no further errors.
- Illegal load: load data_in=14 -> illegal_load pulse, in_sync=0, chk_cnt frozen. Then load data_in=3 -> in_sync=1, exp_count=3, checking resumes.
- Saturation and clear: with SW=4, inject 20 mismatches -> err_cnt=15 and holds; clr -> err_cnt=0, sticky_err=0, exp_count unchanged.
- Async reset mid-run: assert rst between clock edges while state=RESYNC and err_cnt=3 -> outputs zero immediately, in_sync=1, exp_count=0.
